// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and instruction register, drives the
// synchronous instruction RAM and hands one instruction per request to the FSM.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic                  pc_ld,
  input  logic                  br_en,
  input  logic [15:0]           target,
  input  logic [7:0]            disp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc_ins,
  output logic                  busy,
  output logic                  halted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_valid;
  logic                  r_halted;

  logic                  w_redirect;
  logic [ADDR_WIDTH-1:0] w_disp_ext;
  logic [ADDR_WIDTH-1:0] w_redir_pc;

  // Relative base is the already-incremented PC, i.e. the address after the branch.
  assign w_redirect = pc_ld | br_en;
  assign w_disp_ext = {{(ADDR_WIDTH-8){disp[7]}}, disp};
  assign w_redir_pc = pc_ld ? target[ADDR_WIDTH-1:0] : r_pc + w_disp_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_redirect) begin
            r_pc    <= w_redir_pc;
            r_state <= S_IDLE;
          end else if (fetch_req && !r_halted) begin
            r_state <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          // A redirect in flight drops the read data; nothing is delivered.
          if (w_redirect) begin
            r_pc    <= w_redir_pc;
            r_state <= S_IDLE;
          end else begin
            r_instr <= mem_rdata;
            r_pc    <= r_pc + 1'b1;
            r_valid <= 1'b1;
            r_state <= S_DONE;
            if (mem_rdata == '0) r_halted <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr    = r_pc;
  assign pc_ins      = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign busy        = (r_state == S_WAIT);
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for halt/reset
// corners, then random traffic against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, pc_ld, br_en;
  logic [15:0] target;
  logic [7:0]  disp;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic [9:0]  pc_ins;
  logic        busy, halted;

  logic [15:0] ram [0:1023];

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .RESET_PC(10'd0)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_ld(pc_ld), .br_en(br_en),
    .target(target), .disp(disp), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc_ins(pc_ins), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // synchronous RAM: data one cycle after the address is sampled
  always @(posedge clk) mem_rdata <= ram[mem_addr];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int ev, input int ei, input int ep,
                         input int eb, input int eh);
    chk({tag, ".valid"},  int'(instr_valid), ev);
    chk({tag, ".instr"},  int'(instr), ei);
    chk({tag, ".pc_ins"}, int'(pc_ins), ep);
    chk({tag, ".addr"},   int'(mem_addr), ep);
    chk({tag, ".busy"},   int'(busy), eb);
    chk({tag, ".halted"}, int'(halted), eh);
  endtask

  task automatic drive(input logic rq, input logic ld, input logic br,
                       input logic [15:0] tg, input logic [7:0] ds);
    fetch_req = rq; pc_ld = ld; br_en = br; target = tg; disp = ds;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_pc, m_instr, m_valid, m_busy, m_halted;

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_valid = 0; m_busy = 0; m_halted = 0;
  endtask

  // Called just after a clock edge with the inputs that edge sampled.
  task automatic model_step();
    int d, npc;
    d   = $signed(disp);
    npc = pc_ld ? (int'(target) % 1024) : ((m_pc + d) & 1023);
    if (m_busy) begin
      m_busy = 0;
      if (pc_ld || br_en) begin
        m_pc = npc; m_valid = 0;
      end else begin
        m_instr = int'(ram[m_pc]);
        if (m_instr == 0) m_halted = 1;
        m_pc = (m_pc + 1) % 1024;
        m_valid = 1;
      end
    end else begin
      m_valid = 0;
      if (pc_ld || br_en) m_pc = npc;
      else if (fetch_req && m_halted == 0) m_busy = 1;
    end
  endtask

  // async reset asserted mid-cycle, released on the following falling edge
  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #2;
    chk_all(tag, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        rq, ld, br;
    logic [15:0] tg;
    logic [7:0]  ds;
    int          ev, ei, ep, eb;
  } vec_t;

  vec_t tv[$];

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'h1000 + 16'(i);
    ram[0] = 16'h1234; ram[1] = 16'h5678; ram[2] = 16'h9ABC; ram[3] = 16'hDEF0;
    ram[5] = 16'h0000; ram[10'h040] = 16'hABCD; ram[10'h3FF] = 16'h7777;

    //            rq ld br  target     disp   v  instr     pc      busy
    tv.push_back('{1, 0, 0, 16'h0000, 8'h00, 0, 'h0000, 'h000, 1});
    tv.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 'h1234, 'h001, 0});
    tv.push_back('{0, 0, 0, 16'h0000, 8'h00, 0, 'h1234, 'h001, 0});
    tv.push_back('{1, 0, 0, 16'h0000, 8'h00, 0, 'h1234, 'h001, 1});
    tv.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 'h5678, 'h002, 0});
    tv.push_back('{0, 1, 0, 16'hF3FF, 8'h00, 0, 'h5678, 'h3FF, 0});
    tv.push_back('{1, 0, 0, 16'h0000, 8'h00, 0, 'h5678, 'h3FF, 1});
    tv.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 'h7777, 'h000, 0});
    tv.push_back('{0, 0, 1, 16'h0000, 8'hFC, 0, 'h7777, 'h3FC, 0});
    tv.push_back('{0, 1, 0, 16'hF123, 8'h00, 0, 'h7777, 'h123, 0});
    tv.push_back('{0, 1, 1, 16'h0010, 8'h05, 0, 'h7777, 'h010, 0});
    tv.push_back('{1, 0, 0, 16'h0000, 8'h00, 0, 'h7777, 'h010, 1});
    tv.push_back('{1, 1, 0, 16'h0040, 8'h00, 0, 'h7777, 'h040, 0});
    tv.push_back('{1, 0, 0, 16'h0000, 8'h00, 0, 'h7777, 'h040, 1});
    tv.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 'hABCD, 'h041, 0});
    tv.push_back('{0, 0, 1, 16'h0000, 8'h80, 0, 'hABCD, 'h3C1, 0});
    tv.push_back('{1, 0, 1, 16'h0000, 8'h02, 0, 'hABCD, 'h3C3, 0});

    drive(0, 0, 0, 16'h0, 8'h0);
    reset = 1'b0;
    #3;
    chk_all("rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].rq, tv[i].ld, tv[i].br, tv[i].tg, tv[i].ds);
      tick();
      chk_all($sformatf("vec%0d", i), tv[i].ev, tv[i].ei, tv[i].ep, tv[i].eb, 0);
    end

    // fetch_req held high: one instruction every other cycle, sequential addresses
    drive(0, 0, 0, 16'h0, 8'h0);
    pulse_reset("rst2");
    drive(1, 0, 0, 16'h0, 8'h0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c % 2 == 0)
        chk_all($sformatf("stream%0d", c), 1, int'(ram[c/2-1]), c/2, 0, 0);
      else
        chk_all($sformatf("stream%0d", c), 0, (c == 1) ? 0 : int'(ram[c/2-1]), c/2, 1, 0);
    end

    // halt on a zero instruction, then requests are ignored until reset
    drive(0, 0, 0, 16'h0, 8'h0);
    pulse_reset("rst3");
    drive(0, 1, 0, 16'h0005, 8'h0); tick();
    drive(1, 0, 0, 16'h0, 8'h0);    tick();
    drive(0, 0, 0, 16'h0, 8'h0);    tick();
    chk_all("halt", 1, 0, 6, 0, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 16'h0, 8'h0); tick();
      chk_all("halt_req", 0, 0, 6, 0, 1);
      drive(0, 0, 0, 16'h0, 8'h0); tick();
      chk_all("halt_idle", 0, 0, 6, 0, 1);
    end
    drive(0, 0, 1, 16'h0, 8'h03); tick();
    chk_all("halt_br", 0, 0, 9, 0, 1);
    pulse_reset("halt_rst");

    // reset asserted while a fetch is in flight
    drive(0, 1, 0, 16'h0040, 8'h0); tick();
    drive(1, 0, 0, 16'h0, 8'h0);    tick();
    chk_all("mid_wait", 0, 0, 'h40, 1, 0);
    drive(0, 0, 0, 16'h0, 8'h0);
    pulse_reset("mid_rst");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all("post_rst", 0, 0, 0, 0, 0);
    end

    // random traffic against the model
    for (int i = 0; i < 1024; i++)
      ram[i] = ($urandom_range(0, 99) < 3) ? 16'h0000 : 16'($urandom_range(1, 65535));
    pulse_reset("rnd_rst");
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 8, 16'($urandom), 8'($urandom));
      tick();
      model_step();
      chk_all("rnd", m_valid, m_instr, m_pc, m_busy, m_halted);
      if ($urandom_range(0, 99) < 2) begin
        drive(0, 0, 0, 16'h0, 8'h0);
        pulse_reset("rnd_arst");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control FSM.
- Owns the 10-bit program counter and the instruction register.
- Drives the instruction memory read port and delivers one 16-bit instruction per request with a valid pulse.
- Applies absolute (register) and PC-relative redirects, and supplies the link/return address pc_ins.

Parameters:
- ADDR_WIDTH, 10, PC and memory address width
- DATA_WIDTH, 16, instruction width
- RESET_PC, 0, PC value after reset

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- fetch_req  input  1  FSM requests the next instruction
- pc_ld  input  1  absolute redirect: PC <= target[ADDR_WIDTH-1:0]
- br_en  input  1  relative redirect: PC <= PC + sext(disp)
- target  input  16  jump target register value
- disp  input  8  signed branch displacement, two's complement
- mem_addr  output  ADDR_WIDTH  read address to synchronous instruction RAM
- mem_rdata  input  DATA_WIDTH  RAM read data, valid 1 cycle after the address is sampled
- instr  output  DATA_WIDTH  captured instruction
- instr_valid  output  1  one-cycle pulse: instr is new
- pc_ins  output  ADDR_WIDTH  current PC (address of next instruction, used as the link value)
- busy  output  1  fetch in flight (state WAIT)
- halted  output  1  sticky; a 0x0000 instruction was fetched

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC, instr=0x0000, instr_valid=0, halted=0, state=IDLE.
  - mem_addr=RESET_PC, pc_ins=RESET_PC, busy=0.
- Combinational outputs: mem_addr = PC, pc_ins = PC, busy = (state==WAIT).
- States:
  - IDLE: if a redirect is asserted, apply it and stay in IDLE; the request is ignored even if fetch_req=1. Otherwise, if fetch_req=1 and halted=0, go to WAIT. Otherwise stay in IDLE.
  - WAIT:
    - Redirect asserted: apply it, discard mem_rdata, go to IDLE. instr_valid stays 0, instr unchanged, no increment.
    - No redirect: instr <= mem_rdata, PC <= PC+1, instr_valid <= 1, go to DONE.
    - If mem_rdata==0x0000, halted <= 1.
  - DONE: instr_valid=1 for exactly this cycle. Transitions are identical to IDLE, so a back-to-back request is accepted here.
  - fetch_req in WAIT is ignored; there is no queuing.
- Latency: fetch_req sampled high at edge N → instr_valid high during cycle N+2. Maximum throughput is one instruction per 2 cycles.
- Redirect priority: pc_ld over br_en.
- Relative branch base is the current PC, which is the address after the branch instruction, since PC was incremented at capture.
- Arithmetic:
  - Increment and add are modulo 2^ADDR_WIDTH: 0x3FF+1 → 0x000; 0x002 + sext(0xFC) → 0x3FE.
  - target bits above ADDR_WIDTH are ignored.
- halted:
  - Sticky until reset.
  - While halted, fetch_req is ignored; redirects still update PC.
  - The halting instruction itself is still delivered with instr_valid=1.
- Reset asserted mid-fetch: immediate return to reset values. The in-flight read is discarded and no valid pulse is issued after release.
- instr holds its value between fetches.

Test Plan:
1. Reset release with RAM[0]=0x1234, RAM[1]=0x5678; fetch_req pulse at cycle 1 → mem_addr=0 during cycle 1, instr=0x1234 and instr_valid=1 in cycle 3, pc_ins=1; a second request gives instr=0x5678 and pc_ins=2.
2. fetch_req held high continuously → instr_valid high every other cycle, addresses 0,1,2,3 in order, no address skipped or repeated.
3. PC=0x3FF, fetch → pc_ins wraps to 0x000. Then br_en=1, disp=0xFC in IDLE → PC=0x3FC. Then pc_ld=1, target=0xF123 → PC=0x123.
4. pc_ld=1, target=0x040 asserted in WAIT → no instr_valid, instr unchanged, PC=0x040. The next fetch returns RAM[0x40]. Also pc_ld and br_en together → pc_ld wins.
5. RAM[5]=0x0000 fetched → instr_valid=1 with instr=0x0000 and halted=1. Subsequent fetch_req pulses produce no instr_valid. reset=0 clears halted and sets PC=0.
6. reset driven low asynchronously during WAIT (mid-cycle, no clock edge) → instr_valid=0, busy=0, PC=0 immediately; no valid pulse after release until a new fetch_req.
